// File: rtl/cb_alloc_dispatch.sv
// Allocates completion-buffer entries for decoded instructions and queues the tagged ops for issue.
// Allocation is same-cycle, issue follows one cycle later, and a flush or reset discards everything in flight.
module cb_alloc_dispatch #(
  parameter int NUM_ENTRY = 16,
  parameter int QDEPTH    = 4,
  localparam int IW       = $clog2(NUM_ENTRY)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [6:0]    in_opcode,
  input  logic          in_rv32v,
  input  logic          in_wb_scalar,
  output logic          in_ready,
  input  logic          cb_full,
  input  logic [IW-1:0] cb_cur_tail,
  input  logic          cb_flush,
  input  logic          cb_commit,
  output logic          alloc_ena,
  output logic [6:0]    alloc_opcode,
  output logic          alloc_rv32v,
  output logic          alloc_wb_scalar,
  output logic          iss_valid,
  output logic [IW-1:0] iss_index,
  output logic [6:0]    iss_opcode,
  output logic          iss_rv32v,
  input  logic          iss_ready,
  output logic [IW:0]   inflight
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;
  localparam logic [IW:0] INF_MAX = (IW+1)'(NUM_ENTRY);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [6:0]    op;
    logic          rv;
  } ent_t;

  state_t        state_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW:0]   inflight_q, inflight_d;
  ent_t          mem_q [QDEPTH];
  ent_t          head;

  logic run, q_empty, q_full, pop;

  assign run     = (state_q == S_RUN);
  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  // No full-queue bypass: a pop in the same cycle does not open in_ready.
  assign in_ready  = ~RST & run & ~cb_flush & ~cb_full & ~q_full & (inflight_q < INF_MAX);
  assign alloc_ena = in_valid & in_ready & (in_opcode != 7'h00);

  assign alloc_opcode    = in_opcode;
  assign alloc_rv32v     = in_rv32v;
  assign alloc_wb_scalar = in_wb_scalar;

  // Gating on cb_flush keeps a pre-flush entry from escaping in the flush cycle itself.
  assign iss_valid = ~RST & run & ~cb_flush & ~q_empty;
  assign pop       = iss_valid & iss_ready;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign iss_index  = head.idx;
  assign iss_opcode = head.op;
  assign iss_rv32v  = head.rv;
  assign inflight   = inflight_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(alloc_ena);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    inflight_d = inflight_q;
    if (alloc_ena && !cb_commit)
      inflight_d = inflight_q + 1'b1;
    else if (!alloc_ena && cb_commit && inflight_q != '0)
      inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
    end else if (cb_flush) begin
      state_q    <= S_FLUSH;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= S_RUN;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc_ena)
      mem_q[wr_ptr_q[AW-1:0]] <= '{idx: cb_cur_tail, op: in_opcode, rv: in_rv32v};
  end

endmodule

// File: tb/tb_cb_alloc_dispatch.sv
// Scoreboard bench: the driver predicts handshake/occupancy from plain counters and a queue of expected
// issue entries; an independent monitor pops that queue whenever the DUT issues.
module tb_cb_alloc_dispatch;

  localparam int NE = 16;
  localparam int QD = 4;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic [6:0]    in_opcode;
  logic          in_rv32v;
  logic          in_wb_scalar;
  logic          in_ready;
  logic          cb_full;
  logic [IW-1:0] cb_cur_tail;
  logic          cb_flush;
  logic          cb_commit;
  logic          alloc_ena;
  logic [6:0]    alloc_opcode;
  logic          alloc_rv32v;
  logic          alloc_wb_scalar;
  logic          iss_valid;
  logic [IW-1:0] iss_index;
  logic [6:0]    iss_opcode;
  logic          iss_rv32v;
  logic          iss_ready;
  logic [IW:0]   inflight;

  cb_alloc_dispatch #(.NUM_ENTRY(NE), .QDEPTH(QD)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_rv32v(in_rv32v),
    .in_wb_scalar(in_wb_scalar), .in_ready(in_ready),
    .cb_full(cb_full), .cb_cur_tail(cb_cur_tail), .cb_flush(cb_flush), .cb_commit(cb_commit),
    .alloc_ena(alloc_ena), .alloc_opcode(alloc_opcode), .alloc_rv32v(alloc_rv32v),
    .alloc_wb_scalar(alloc_wb_scalar),
    .iss_valid(iss_valid), .iss_index(iss_index), .iss_opcode(iss_opcode),
    .iss_rv32v(iss_rv32v), .iss_ready(iss_ready), .inflight(inflight)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int idx;
    int op;
    int rv;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   pop_seen = 1'b0;
  bit   m_run    = 1'b1;   // model: 1 = accepting/issuing, 0 = the one cycle after a flush
  int   m_inflight = 0;
  int   tail_m   = 0;      // stand-in for the completion buffer's tail pointer

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: issue side only.
  always @(negedge CLK) begin : monitor
    bit   ev;
    ent_t e;
    if (mon_en) begin
      ev = !RST && m_run && !cb_flush && (exp_q.size() > 0);
      chk("iss_valid", {31'd0, iss_valid}, {31'd0, ev});
      if (ev && iss_ready) begin
        e = exp_q.pop_front();
        chk("iss_index",  {28'd0, iss_index},  e.idx);
        chk("iss_opcode", {25'd0, iss_opcode}, e.op);
        chk("iss_rv32v",  {31'd0, iss_rv32v},  e.rv);
        pop_seen = 1'b1;
      end
    end
  end

  task automatic cyc(input bit v, input bit [6:0] op, input bit rv, input bit wb, input bit full,
                     input bit flush, input bit commit, input bit rdy, input bit rst);
    int occ;
    bit exp_rdy, exp_alloc;
    ent_t e;
    @(posedge CLK); #1;
    RST = rst; in_valid = v; in_opcode = op; in_rv32v = rv; in_wb_scalar = wb;
    cb_full = full; cb_flush = flush; cb_commit = commit; iss_ready = rdy;
    cb_cur_tail = IW'(tail_m);
    @(negedge CLK); #1;
    occ       = exp_q.size() + (pop_seen ? 1 : 0);
    exp_rdy   = !rst && m_run && !flush && !full && (occ < QD) && (m_inflight < NE);
    exp_alloc = v && exp_rdy && (op != 0);
    chk("in_ready",  {31'd0, in_ready},  {31'd0, exp_rdy});
    chk("alloc_ena", {31'd0, alloc_ena}, {31'd0, exp_alloc});
    chk("inflight",  {27'd0, inflight},  m_inflight);
    if (exp_alloc) begin
      chk("alloc_opcode",    {25'd0, alloc_opcode},    {25'd0, op});
      chk("alloc_wb_scalar", {31'd0, alloc_wb_scalar}, {31'd0, wb});
    end
    pop_seen = 1'b0;
    if (rst || flush) begin
      m_run = !flush || rst;
      m_inflight = 0;
      exp_q.delete();
      tail_m = 0;
    end else begin
      m_run = 1'b1;
      if (exp_alloc) begin
        e.idx = tail_m; e.op = op; e.rv = rv;
        exp_q.push_back(e);
        tail_m = (tail_m + 1) % NE;
      end
      if (exp_alloc && !commit) m_inflight++;
      else if (!exp_alloc && commit && m_inflight > 0) m_inflight--;
    end
  endtask

  task automatic rand_cyc(input int p_rdy, input int p_commit, input int p_flush, input int p_rst);
    bit [6:0] op;
    op = ($urandom_range(0, 99) < 15) ? 7'h00 : 7'($urandom_range(1, 127));
    cyc($urandom_range(0, 99) < 80, op, 1'($urandom), 1'($urandom),
        $urandom_range(0, 99) < 10, $urandom_range(0, 99) < p_flush,
        $urandom_range(0, 99) < p_commit, $urandom_range(0, 99) < p_rdy,
        $urandom_range(0, 99) < p_rst);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b1; in_opcode = 7'h33; in_rv32v = 1'b0; in_wb_scalar = 1'b0;
    cb_full = 1'b0; cb_cur_tail = '0; cb_flush = 1'b0; cb_commit = 1'b0; iss_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready",  {31'd0, in_ready},  0);
    chk("rst_alloc_ena", {31'd0, alloc_ena}, 0);
    chk("rst_iss_valid", {31'd0, iss_valid}, 0);
    chk("rst_inflight",  {27'd0, inflight},  0);
    mon_en = 1'b1;

    // Basic allocate at tail 5, issued the following cycle.
    tail_m = 5;
    cyc(1, 7'h33, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 7'h00, 0, 0, 0, 0, 0, 1, 0);
    // Bubble: accepted, nothing allocated.
    cyc(1, 7'h00, 0, 0, 0, 0, 0, 1, 0);
    // Five back-to-back allocations with no issue, then one pop.
    tail_m = 0;
    for (int i = 0; i < 5; i++) cyc(1, 7'(i + 1), 1'(i), 0, 0, 0, 0, 0, 0);
    cyc(1, 7'h11, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 7'h12, 0, 0, 0, 0, 0, 0, 0);
    // Fill up to the in-flight limit, then a commit alongside an offered alloc.
    for (int i = 0; i < 24; i++) cyc(1, 7'h21, 0, 1, 0, 0, 0, 1, 0);
    chk("inflight_full", {27'd0, inflight}, NE);
    cyc(1, 7'h22, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 7'h23, 0, 0, 0, 0, 1, 1, 0);
    // Flush with entries queued; first post-flush allocation gets tail 0.
    for (int i = 0; i < 16; i++) cyc(0, 7'h00, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 7'h31, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7'h32, 0, 0, 0, 1, 0, 1, 0);
    cyc(1, 7'h34, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 7'h35, 1, 0, 0, 0, 0, 1, 0);
    cyc(0, 7'h00, 0, 0, 0, 0, 0, 1, 0);
    // Mid-operation reset with entries queued.
    for (int i = 0; i < 7; i++) cyc(1, 7'h41, 0, 0, 0, 0, 0, i > 4, 0);
    cyc(1, 7'h42, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 7'h43, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 800; i++) rand_cyc(20, 30, 1, 0);
    for (int i = 0; i < 800; i++) rand_cyc(90, 3, 1, 1);
    for (int i = 0; i < 800; i++) rand_cyc(70, 60, 2, 1);
    for (int i = 0; i < 800; i++) rand_cyc(50, 40, 6, 2);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
